// File: rtl/arcade_memory_map.sv
// Memory map for 8080-class arcade cores: banked download ROM, duplicated work/video RAM
// with clear-after-load sequencing, colour store, per-game CPU address scrambling.
module arcade_memory_map #(
   parameter int ROM_AW    = 13,
   parameter int ROM_BANKS = 2,
   parameter int RAM_AW    = 13,
   parameter int COL_AW    = 11
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_dn_download,
   input  logic              i_dn_wr,
   input  logic [15:0]       i_dn_addr,
   input  logic [7:0]        i_dn_data,
   input  logic [1:0]        i_mode,
   input  logic [15:0]       i_cpu_addr,
   input  logic [7:0]        i_cpu_din,
   input  logic              i_cpu_wr,
   output logic [7:0]        o_cpu_dout,
   output logic              o_cpu_ready,
   input  logic [RAM_AW-1:0] i_vid_addr,
   output logic [7:0]        o_vid_data,
   output logic [7:0]        o_vid_next,
   input  logic [COL_AW-1:0] i_col_addr,
   output logic [7:0]        o_col_data
);

   // state | meaning
   // CLEAR | zero-fill work RAM, one address per cycle, CPU held off
   // LOAD  | HPS download in progress, CPU held off
   // RUN   | CPU accesses accepted

   localparam int ROM_DEPTH = ROM_BANKS << ROM_AW;
   localparam int ROM_IW    = $clog2(ROM_DEPTH);

   typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_ROM, SRC_RAM, SRC_COL} src_t;

   logic [7:0] r_rom   [ROM_DEPTH];
   logic [7:0] r_ram_a [2**RAM_AW];
   logic [7:0] r_ram_b [2**RAM_AW];
   logic [7:0] r_col   [2**COL_AW];

   state_t            r_state, w_state_next;
   logic [RAM_AW-1:0] r_clr_cnt;
   logic              r_ready, w_ready_next;
   src_t              r_src, w_src;
   logic [7:0]        r_rom_q, r_ram_q, r_colc_q;
   logic [7:0]        r_vid_data, r_vid_next, r_col_data;

   logic [15:0]       w_sa;
   logic [31:0]       w_bank, w_dn_region;
   logic              w_rom_hit, w_ram_hit, w_col_hit;
   logic [ROM_IW-1:0] w_rom_ridx, w_rom_widx;
   logic [RAM_AW-1:0] w_ram_off, w_ram_waddr, w_vid_addr_p1;
   logic [7:0]        w_ram_wdata, w_col_wdata;
   logic [COL_AW-1:0] w_col_cpu_off, w_col_waddr;
   logic              w_dn_we, w_dn_rom_we, w_dn_col_we, w_cpu_we;
   logic              w_ram_we, w_col_we, w_clearing;

   always_comb begin
      w_sa = i_cpu_addr;
      case (i_mode)
         2'd1:    w_sa = i_cpu_addr ^ 16'h0209;
         2'd2:    begin
                     w_sa[9] = i_cpu_addr[8];
                     w_sa[8] = i_cpu_addr[9];
                  end
         default: w_sa = i_cpu_addr;
      endcase
   end

   assign w_bank        = 32'(w_sa[15:14]);
   assign w_rom_hit     = !w_sa[13] && (w_bank < ROM_BANKS);
   assign w_ram_hit     = (w_sa[15:13] == 3'b001);
   assign w_col_hit     = (i_mode == 2'd3) && (w_sa[15:10] == 6'b010111);
   assign w_rom_ridx    = ROM_IW'({w_sa[15:14], w_sa[ROM_AW-1:0]});
   assign w_ram_off     = w_sa[RAM_AW-1:0];
   assign w_col_cpu_off = COL_AW'(w_sa[9:0]);

   // Colour RAM sits on top of ROM bank 1, so it takes priority.
   always_comb begin
      w_src = SRC_NONE;
      if (w_col_hit)      w_src = SRC_COL;
      else if (w_ram_hit) w_src = SRC_RAM;
      else if (w_rom_hit) w_src = SRC_ROM;
   end

   assign w_dn_region = 32'(i_dn_addr[15:ROM_AW]);
   assign w_dn_we     = i_dn_download && i_dn_wr;
   assign w_dn_rom_we = w_dn_we && (w_dn_region < ROM_BANKS);
   assign w_dn_col_we = w_dn_we && (w_dn_region == ROM_BANKS);
   assign w_rom_widx  = i_dn_addr[ROM_IW-1:0];
   assign w_cpu_we    = r_ready && i_cpu_wr;

   assign w_col_we    = w_dn_col_we || (w_cpu_we && (w_src == SRC_COL));
   assign w_col_waddr = w_dn_col_we ? i_dn_addr[COL_AW-1:0] : w_col_cpu_off;
   assign w_col_wdata = w_dn_col_we ? i_dn_data : i_cpu_din;

   assign w_clearing  = (r_state == ST_CLEAR);
   assign w_ram_we    = w_clearing || (w_cpu_we && (w_src == SRC_RAM));
   assign w_ram_waddr = w_clearing ? r_clr_cnt : w_ram_off;
   assign w_ram_wdata = w_clearing ? 8'h00 : i_cpu_din;

   assign w_vid_addr_p1 = i_vid_addr + RAM_AW'(1);

   always_comb begin
      w_state_next = r_state;
      w_ready_next = 1'b0;
      case (r_state)
         ST_CLEAR: if (r_clr_cnt == '1) w_state_next = i_dn_download ? ST_LOAD : ST_RUN;
         ST_LOAD:  if (!i_dn_download) w_state_next = ST_CLEAR;
         ST_RUN:   begin
                      if (i_dn_download) w_state_next = ST_LOAD;
                      w_ready_next = !i_dn_download;
                   end
         default:  w_state_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_CLEAR;
         r_clr_cnt  <= '0;
         r_ready    <= 1'b0;
         r_src      <= SRC_NONE;
         r_rom_q    <= 8'h00;
         r_ram_q    <= 8'h00;
         r_colc_q   <= 8'h00;
         r_vid_data <= 8'h00;
         r_vid_next <= 8'h00;
         r_col_data <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_clr_cnt  <= w_clearing ? r_clr_cnt + RAM_AW'(1) : '0;
         r_ready    <= w_ready_next;
         r_src      <= w_src;
         r_rom_q    <= w_rom_hit ? r_rom[w_rom_ridx] : 8'h00;
         r_ram_q    <= r_ram_a[w_ram_off];
         r_colc_q   <= r_col[w_col_cpu_off];
         r_vid_data <= r_ram_a[i_vid_addr];
         r_vid_next <= r_ram_b[w_vid_addr_p1];
         r_col_data <= r_col[i_col_addr];
      end
   end

   // Storage is deliberately not reset so downloaded content survives a core reset.
   always_ff @(posedge i_clk) begin
      if (w_dn_rom_we) r_rom[w_rom_widx] <= i_dn_data;
      if (w_ram_we) begin
         r_ram_a[w_ram_waddr] <= w_ram_wdata;
         r_ram_b[w_ram_waddr] <= w_ram_wdata;
      end
      if (w_col_we) r_col[w_col_waddr] <= w_col_wdata;
   end

   always_comb begin
      case (r_src)
         SRC_ROM: o_cpu_dout = r_rom_q;
         SRC_RAM: o_cpu_dout = r_ram_q;
         SRC_COL: o_cpu_dout = r_colc_q;
         default: o_cpu_dout = 8'h00;
      endcase
   end

   assign o_cpu_ready = r_ready;
   assign o_vid_data  = r_vid_data;
   assign o_vid_next  = r_vid_next;
   assign o_col_data  = r_col_data;

endmodule

// File: tb/tb_arcade_memory_map.sv
// Bench for arcade_memory_map: vector tables plus hand sequences, results checked
// through a one-cycle-latency scoreboard.
module tb_arcade_memory_map;

   localparam int RAM_AW = 13;
   localparam int COL_AW = 11;
   localparam int CLEAR_LAT = (1 << RAM_AW) + 1;

   localparam int K_RD  = 0;
   localparam int K_WR  = 1;
   localparam int K_VID = 2;
   localparam int K_COL = 3;

   localparam int P_DOUT  = 0;
   localparam int P_VDATA = 1;
   localparam int P_VNEXT = 2;
   localparam int P_COL   = 3;
   localparam int P_READY = 4;

   typedef struct {
      string      name;
      int         kind;
      logic [15:0] addr;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } vec_t;

   typedef struct {
      string      name;
      int         port;
      logic [7:0] exp;
   } sb_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              dn_download, dn_wr;
   logic [15:0]       dn_addr;
   logic [7:0]        dn_data;
   logic [1:0]        mode;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_din;
   logic              cpu_wr;
   logic [7:0]        cpu_dout;
   logic              cpu_ready;
   logic [RAM_AW-1:0] vid_addr;
   logic [7:0]        vid_data, vid_next;
   logic [COL_AW-1:0] col_addr;
   logic [7:0]        col_data;

   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;
   sb_t  sb_q[$];
   vec_t vecs[$];

   arcade_memory_map dut (
      .i_clk(clk), .i_rst(rst),
      .i_dn_download(dn_download), .i_dn_wr(dn_wr), .i_dn_addr(dn_addr), .i_dn_data(dn_data),
      .i_mode(mode),
      .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .i_cpu_wr(cpu_wr),
      .o_cpu_dout(cpu_dout), .o_cpu_ready(cpu_ready),
      .i_vid_addr(vid_addr), .o_vid_data(vid_data), .o_vid_next(vid_next),
      .i_col_addr(col_addr), .o_col_data(col_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input string name, input int port, input logic [7:0] exp);
      sb_t e;
      e.name = name;
      e.port = port;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      sb_t        e;
      logic [7:0] act;
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         case (e.port)
            P_DOUT:  act = cpu_dout;
            P_VDATA: act = vid_data;
            P_VNEXT: act = vid_next;
            P_COL:   act = col_data;
            default: act = {7'b0, cpu_ready};
         endcase
         check(e.name, 32'(act), 32'(e.exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!cpu_ready && n < 20000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic dn_write(input logic [15:0] a, input logic [7:0] d);
      dn_addr = a;
      dn_data = d;
      dn_wr   = 1'b1;
      tick();
      dn_wr   = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      case (v.kind)
         K_RD: begin
            cpu_addr = v.addr;
            push(v.name, P_DOUT, v.exp_a);
            tick();
         end
         K_WR: begin
            cpu_addr = v.addr;
            cpu_din  = v.exp_a;
            cpu_wr   = 1'b1;
            tick();
            cpu_wr   = 1'b0;
         end
         K_VID: begin
            vid_addr = v.addr[RAM_AW-1:0];
            push({v.name, "_data"}, P_VDATA, v.exp_a);
            push({v.name, "_next"}, P_VNEXT, v.exp_b);
            tick();
         end
         default: begin
            col_addr = v.addr[COL_AW-1:0];
            push(v.name, P_COL, v.exp_a);
            tick();
         end
      endcase
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
      vecs.delete();
   endtask

   initial begin
      rst = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
      mode = 2'd0; cpu_addr = '0; cpu_din = '0; cpu_wr = 1'b0; vid_addr = '0; col_addr = '0;

      // Reset state
      tick();
      push("rst_dout", P_DOUT, 8'h00);
      push("rst_vdata", P_VDATA, 8'h00);
      push("rst_vnext", P_VNEXT, 8'h00);
      push("rst_col", P_COL, 8'h00);
      push("rst_ready", P_READY, 8'h00);
      tick();
      rst = 1'b0;
      wait_ready(lat);
      check("ready_latency_por", 32'(lat), 32'(CLEAR_LAT));

      // Mode 0 RUN: RAM access and video wrap
      vecs.push_back('{"ram_2000_clr", K_RD,  16'h2000, 8'h00, 8'h00});
      vecs.push_back('{"ram_3fff_clr", K_RD,  16'h3FFF, 8'h00, 8'h00});
      vecs.push_back('{"wr_2000",      K_WR,  16'h2000, 8'hAA, 8'h00});
      vecs.push_back('{"wr_3fff",      K_WR,  16'h3FFF, 8'h55, 8'h00});
      vecs.push_back('{"ram_2000_aa",  K_RD,  16'h2000, 8'hAA, 8'h00});
      vecs.push_back('{"ram_3fff_55",  K_RD,  16'h3FFF, 8'h55, 8'h00});
      vecs.push_back('{"vid_wrap",     K_VID, 16'h1FFF, 8'h55, 8'hAA});
      run_vecs();

      // Video read of an address written in the same cycle returns old data
      vid_addr = 13'h000F;
      cpu_addr = 16'h2010;
      cpu_din  = 8'h66;
      cpu_wr   = 1'b1;
      push("rbw_old_next", P_VNEXT, 8'h00);
      tick();
      cpu_wr = 1'b0;
      push("rbw_new_next", P_VNEXT, 8'h66);
      push("rbw_data", P_VDATA, 8'h00);
      tick();

      // Enter LOAD: ready drops, CPU write discarded, downloads land
      dn_download = 1'b1;
      push("ready_drop", P_READY, 8'h00);
      tick();
      vecs.push_back('{"wr_2000_load", K_WR, 16'h2000, 8'h99, 8'h00});
      vecs.push_back('{"discard_load", K_RD, 16'h2000, 8'hAA, 8'h00});
      run_vecs();
      dn_write(16'h0005, 8'h11);
      dn_write(16'h2005, 8'h22);
      dn_write(16'h0201, 8'h5A);
      dn_write(16'h0100, 8'h77);
      dn_write(16'h4010, 8'h3C);
      dn_write(16'h4020, 8'h9C);
      dn_write(16'h6010, 8'hEE);

      mode = 2'd1;
      vecs.push_back('{"mode1_scramble", K_RD, 16'h0008, 8'h5A, 8'h00});
      run_vecs();
      mode = 2'd2;
      vecs.push_back('{"mode2_swap", K_RD, 16'h0200, 8'h77, 8'h00});
      run_vecs();
      mode = 2'd3;

      // Drop download, then reset mid-CLEAR: full count restarts
      dn_download = 1'b0;
      tick();
      repeat (100) tick();
      push("ready_low_mid_clear", P_READY, 8'h00);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(lat);
      check("ready_latency_mid_clear_reset", 32'(lat), 32'(CLEAR_LAT));

      // Mode 3 RUN: RAM cleared, colour RAM writable
      vecs.push_back('{"clr_2000",      K_RD,  16'h2000, 8'h00, 8'h00});
      vecs.push_back('{"clr_3fff",      K_RD,  16'h3FFF, 8'h00, 8'h00});
      vecs.push_back('{"clr_2010",      K_RD,  16'h2010, 8'h00, 8'h00});
      vecs.push_back('{"clr_vid",       K_VID, 16'h1FFF, 8'h00, 8'h00});
      vecs.push_back('{"col_dl_kept",   K_COL, 16'h0010, 8'h3C, 8'h00});
      vecs.push_back('{"wr_col_m3",     K_WR,  16'h5C10, 8'hC3, 8'h00});
      vecs.push_back('{"rd_col_m3",     K_RD,  16'h5C10, 8'hC3, 8'h00});
      vecs.push_back('{"col_port_m3",   K_COL, 16'h0010, 8'hC3, 8'h00});
      vecs.push_back('{"rom1_m3",       K_RD,  16'h4005, 8'h22, 8'h00});
      run_vecs();

      // Download and CPU colour write collide: download wins (also enters LOAD)
      dn_download = 1'b1;
      dn_wr    = 1'b1;
      dn_addr  = 16'h4030;
      dn_data  = 8'h44;
      cpu_addr = 16'h5C30;
      cpu_din  = 8'h88;
      cpu_wr   = 1'b1;
      tick();
      dn_wr  = 1'b0;
      cpu_wr = 1'b0;
      vecs.push_back('{"col_collision", K_COL, 16'h0030, 8'h44, 8'h00});
      run_vecs();
      mode = 2'd0;
      dn_download = 1'b0;
      tick();
      wait_ready(lat);
      check("ready_latency_after_load", 32'(lat), 32'(CLEAR_LAT));

      // Mode 0 RUN: decode map, ROM write protect, colour untouched
      vecs.push_back('{"rom0",          K_RD,  16'h0005, 8'h11, 8'h00});
      vecs.push_back('{"rom1",          K_RD,  16'h4005, 8'h22, 8'h00});
      vecs.push_back('{"unmapped_8005", K_RD,  16'h8005, 8'h00, 8'h00});
      vecs.push_back('{"unmapped_6005", K_RD,  16'h6005, 8'h00, 8'h00});
      vecs.push_back('{"ram_2000_m0",   K_RD,  16'h2000, 8'h00, 8'h00});
      vecs.push_back('{"col_020",       K_COL, 16'h0020, 8'h9C, 8'h00});
      vecs.push_back('{"wr_5c10_m0",    K_WR,  16'h5C10, 8'h11, 8'h00});
      vecs.push_back('{"col_m0_kept",   K_COL, 16'h0010, 8'hC3, 8'h00});
      vecs.push_back('{"wr_rom0",       K_WR,  16'h0005, 8'hEE, 8'h00});
      vecs.push_back('{"rom0_protect",  K_RD,  16'h0005, 8'h11, 8'h00});
      run_vecs();

      // dn_wr without dn_download is ignored
      dn_write(16'h0005, 8'hFF);
      dn_write(16'h4010, 8'hFF);
      vecs.push_back('{"dn_wr_no_dl_rom", K_RD,  16'h0005, 8'h11, 8'h00});
      vecs.push_back('{"dn_wr_no_dl_col", K_COL, 16'h0010, 8'hC3, 8'h00});
      vecs.push_back('{"ready_still_run", K_RD,  16'h2000, 8'h00, 8'h00});
      run_vecs();
      push("ready_run", P_READY, 8'h01);
      tick();

      drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
